maxpool_stream: RTL and testbench
=================================

MAXPOOL_STREAM -- requirements
Module: maxpool_stream

Interface
REQ-001 SHALL have parameter CONV_SIZE, default 4: width and height of the square conv result map streamed in.
REQ-002 SHALL have parameter DATA_W, default 48: signed sample width, taken from conv_pkg.
REQ-003 SHALL have port i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_go  input  1  start-of-frame pulse.
REQ-006 SHALL have port i_valid  input  1  qualifies i_data for one cycle.
REQ-007 SHALL have port i_data  input  DATA_W  signed conv result, row-major raster order.
REQ-008 SHALL have port o_valid  output  1  qualifies o_data for one cycle.
REQ-009 SHALL have port o_data  output  DATA_W  signed 2x2 pooled maximum, row-major.
REQ-010 SHALL have port o_done  output  1  one-cycle end-of-frame pulse.

Function
REQ-011 SHALL implement FSM states IDLE, RUN and DONE.
REQ-012 SHALL move IDLE->RUN on i_go, RUN->DONE when sample CONV_SIZE*CONV_SIZE is accepted, and DONE->IDLE unconditionally after one cycle.
REQ-013 SHALL ignore i_valid in IDLE and DONE; SHALL ignore i_go in RUN and DONE.
REQ-014 SHALL keep row and column counters that advance only on accepted samples; the column counter wraps at CONV_SIZE-1 and increments the row counter.
REQ-015 SHALL compare values as signed; on equal values the output is that value.
REQ-016 SHALL hold the even-column sample of each pair in a register and take the pair maximum on the odd-column sample.
REQ-017 SHALL, on even rows, write each pair maximum into row-buffer entry col/2.
REQ-018 SHALL, on odd rows, combine each pair maximum with row-buffer entry col/2.
REQ-019 SHALL register the REQ-018 result onto o_data and pulse o_valid exactly one cycle after the completing sample is accepted.
REQ-020 SHALL produce floor(CONV_SIZE/2)^2 outputs per frame.
REQ-021 SHALL drop the last column when CONV_SIZE is odd; such samples are accepted and counted but never stored.
REQ-022 SHALL drop the last row when CONV_SIZE is odd; such samples are accepted and counted but produce no output.
REQ-023 SHALL pulse o_done in the DONE state, one cycle after the final sample is accepted; this coincides with the final o_valid when CONV_SIZE is even.
REQ-024 SHALL accept gaps of any length between i_valid pulses with no effect on results; the block has no backpressure.
REQ-025 SHALL hold o_data at its last value when o_valid is low.

Reset
REQ-026 SHALL, on i_rst, immediately force: state IDLE, counters 0, o_valid 0, o_done 0, o_data 0, pair register 0.
REQ-027 SHALL abandon a frame when reset is asserted mid-frame; the next frame requires a new i_go.
REQ-028 SHALL NOT require row-buffer contents to be reset.

Configuration
REQ-029 SHALL, with macro MAXPOOL_RELU_EN defined, replace every negative accepted sample by 0 before comparison, so that o_data >= 0.
REQ-030 SHALL, without MAXPOOL_RELU_EN, pass samples unmodified and allow negative outputs.

Structure
REQ-031 SHALL take DATA_W and the FSM state enumeration from shared package conv_pkg.
REQ-032 SHALL place the row buffer in sub-module pool_row_buf: depth floor(CONV_SIZE/2), width DATA_W, one write port, one combinational read port.

Verification
REQ-033 SHALL cover: CONV_SIZE=4, i_go, inputs 0..15 back-to-back -> o_data 5,7,13,15; o_done on the cycle of the last o_valid.
REQ-034 SHALL cover: CONV_SIZE=4, all inputs -(i+1) for i=0..15 -> outputs -1,-3,-9,-11 without the macro; 0,0,0,0 with MAXPOOL_RELU_EN.
REQ-035 SHALL cover: CONV_SIZE=5, inputs 0..24 -> outputs 6,8,16,18 only; o_done one cycle after sample 24.
REQ-036 SHALL cover: the REQ-033 stream with random 0-3 cycle i_valid gaps and a second i_go mid-frame -> identical outputs and a single o_done.
REQ-037 SHALL cover: i_rst asserted after sample 7, then a new i_go and the full REQ-033 stream -> no output before the restart, then 5,7,13,15.
REQ-038 SHALL cover: i_valid pulses while IDLE before i_go -> no o_valid, and counters still 0 at start.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared sample width and pooling FSM state encoding for the conv pipeline
package conv_pkg;
  localparam int DATA_W = 48;
  typedef enum logic [1:0] {IDLE, RUN, DONE} pool_state_t;
endpackage

// File: rtl/pool_row_buf.sv
// pool_row_buf: holds one row of horizontal pair maxima until the matching odd row arrives
// ports: clk, we/waddr/wdata write port, raddr/rdata combinational read port
module pool_row_buf #(
  parameter int DEPTH = 2,
  parameter int DATA_W = 48,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic [AW-1:0]            raddr,
  output logic signed [DATA_W-1:0] rdata
);
  logic signed [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/maxpool_stream.sv
// maxpool_stream: streaming 2x2 signed max-pool over a CONV_SIZE x CONV_SIZE raster frame
// ports: i_clk, i_rst (async high), i_go frame start, i_valid/i_data samples in,
//        o_valid/o_data pooled maxima out, o_done end-of-frame pulse
// MAXPOOL_RELU_EN: clamp negative samples to 0 before pooling
module maxpool_stream #(
  parameter int CONV_SIZE = 4,
  parameter int DATA_W = conv_pkg::DATA_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_go,
  input  logic                     i_valid,
  input  logic signed [DATA_W-1:0] i_data,
  output logic                     o_valid,
  output logic signed [DATA_W-1:0] o_data,
  output logic                     o_done
);
  import conv_pkg::*;
  localparam int HALF = CONV_SIZE / 2;
  localparam int CW = $clog2(CONV_SIZE);
  localparam int AW = HALF > 1 ? $clog2(HALF) : 1;
  pool_state_t state;
  logic [CW-1:0] row, col;
  logic [AW-1:0] addr;
  logic signed [DATA_W-1:0] pair, s, pmax, rd, omax;
  logic acc, last, col_end, keep_col, keep_row;
  assign acc = state == RUN && i_valid;
`ifdef MAXPOOL_RELU_EN
  assign s = i_data[DATA_W-1] ? '0 : i_data;
`else
  assign s = i_data;
`endif
  assign col_end = col == CW'(CONV_SIZE - 1);
  assign last = col_end && row == CW'(CONV_SIZE - 1);
  // trailing row/column of an odd-sized map has no partner and is dropped
  assign keep_col = 32'(col) < 2 * HALF;
  assign keep_row = 32'(row) < 2 * HALF;
  assign addr = AW'(col >> 1);
  assign pmax = s > pair ? s : pair;
  assign omax = pmax > rd ? pmax : rd;
  pool_row_buf #(.DEPTH(HALF), .DATA_W(DATA_W)) u_row_buf (
    .clk(i_clk),
    .we(acc && col[0] && !row[0] && keep_row),
    .waddr(addr),
    .wdata(pmax),
    .raddr(addr),
    .rdata(rd)
  );
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= IDLE;
      row <= '0;
      col <= '0;
      pair <= '0;
      o_valid <= 1'b0;
      o_done <= 1'b0;
      o_data <= '0;
    end else begin
      o_valid <= 1'b0;
      o_done <= 1'b0;
      if (acc && !col[0] && keep_col) pair <= s;
      if (acc && col[0] && row[0] && keep_row) begin
        o_data <= omax;
        o_valid <= 1'b1;
      end
      if (acc) begin
        col <= col_end ? '0 : col + 1'b1;
        row <= last ? '0 : col_end ? row + 1'b1 : row;
      end
      case (state)
        IDLE: if (i_go) begin
          state <= RUN;
          row <= '0;
          col <= '0;
        end
        RUN: if (acc && last) begin
          state <= DONE;
          o_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_maxpool_stream.sv
// tb_maxpool_stream: directed checks of maxpool_stream at CONV_SIZE 4 and 5
module tb_maxpool_stream;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic g4 = 0, v4 = 0, g5 = 0, v5 = 0;
  logic signed [47:0] d4 = '0, d5 = '0;
  logic ov4, od4, ov5, od5;
  logic signed [47:0] o4, o5;
  maxpool_stream #(.CONV_SIZE(4)) u4 (
    .i_clk(clk), .i_rst(rst), .i_go(g4), .i_valid(v4), .i_data(d4),
    .o_valid(ov4), .o_data(o4), .o_done(od4)
  );
  maxpool_stream #(.CONV_SIZE(5)) u5 (
    .i_clk(clk), .i_rst(rst), .i_go(g5), .i_valid(v5), .i_data(d5),
    .o_valid(ov5), .o_data(o5), .o_done(od5)
  );
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  longint q4[$], q5[$];
  int nd4, nd5, dc4, dc5, lv4, dl5;
  always @(negedge clk) begin
    if (ov4) begin
      q4.push_back(longint'(o4));
      lv4 = cyc;
    end
    if (od4) begin
      nd4++;
      dc4 = cyc;
    end
    if (ov5) q5.push_back(longint'(o5));
    if (od5) begin
      nd5++;
      dc5 = cyc;
    end
  end
  int tests = 0, fails = 0;
  task automatic check(string tag, longint got, longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic check_q4(string tag, longint e[4]);
    check({tag, " count"}, q4.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < q4.size()) check($sformatf("%s out%0d", tag, i), q4[i], e[i]);
  endtask
  task automatic clear();
    q4.delete();
    q5.delete();
    nd4 = 0;
    nd5 = 0;
  endtask
  task automatic settle(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask
  task automatic go4();
    g4 = 1;
    @(negedge clk);
    g4 = 0;
  endtask
  task automatic push4(longint d, bit g);
    d4 = 48'(d);
    v4 = 1;
    g4 = g;
    @(negedge clk);
    v4 = 0;
    g4 = 0;
  endtask
  task automatic push5(longint d);
    d5 = 48'(d);
    v5 = 1;
    dl5 = cyc;
    @(negedge clk);
    v5 = 0;
  endtask
  task automatic stream4();
    go4();
    for (int i = 0; i < 16; i++) push4(i, 0);
    settle(3);
  endtask
  longint e_up[4] = '{5, 7, 13, 15};
`ifdef MAXPOOL_RELU_EN
  longint e_neg[4] = '{0, 0, 0, 0};
`else
  longint e_neg[4] = '{-1, -3, -9, -11};
`endif
  longint e5[4] = '{6, 8, 16, 18};
  initial begin
    settle(2);
    check("rst ov4", ov4, 0);
    check("rst od4", od4, 0);
    check("rst o4", o4, 0);
    check("rst ov5", ov5, 0);
    check("rst od5", od5, 0);
    check("rst o5", o5, 0);
    rst = 0;
    clear();
    stream4();
    check_q4("ramp", e_up);
    check("ramp done count", nd4, 1);
    check("ramp done with last valid", dc4, lv4);
    settle(2);
    check("hold o_data", o4, 15);
    check("hold o_valid low", ov4, 0);
    clear();
    go4();
    for (int i = 0; i < 16; i++) push4(-(i + 1), 0);
    settle(3);
    check_q4("negative", e_neg);
    clear();
    g5 = 1;
    @(negedge clk);
    g5 = 0;
    for (int i = 0; i < 25; i++) push5(i);
    settle(3);
    check("odd count", q5.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < q5.size()) check($sformatf("odd out%0d", i), q5[i], e5[i]);
    check("odd done count", nd5, 1);
    check("odd done timing", dc5, dl5 + 1);
    clear();
    go4();
    for (int i = 0; i < 16; i++) begin
      push4(i, i == 6);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    settle(3);
    check_q4("gaps", e_up);
    check("gaps done count", nd4, 1);
    check("gaps done with last valid", dc4, lv4);
    clear();
    go4();
    for (int i = 0; i < 8; i++) push4(i, 0);
    settle(2);
    check("abort pre outputs", q4.size(), 2);
    clear();
    rst = 1;
    #1;
    check("abort ov4", ov4, 0);
    check("abort o4", o4, 0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 4; i++) push4(50 + i, 0);
    settle(2);
    check("abort no output", q4.size(), 0);
    check("abort no done", nd4, 0);
    stream4();
    check_q4("restart", e_up);
    clear();
    push4(100, 0);
    push4(-7, 0);
    push4(300, 0);
    settle(2);
    check("idle no output", q4.size(), 0);
    check("idle no done", nd4, 0);
    stream4();
    check_q4("after idle", e_up);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
